baccarat_deal_ctrl: RTL and testbench
=====================================

Name: baccarat_deal_ctrl

Overview:
- Sequencing FSM for one baccarat round.
- Issues one-cycle load enables to the six card registers in the datapath, in the order P1, D1, P2, D2, then optional P3 and D3.
- Applies the natural and third-card rules using the datapath's combinational scores.
- Drives registered win lights, which the datapath's seven-segment decoders sit alongside.

Parameters:
- CARD_W, 4, width of a raw card code (1=A, 2..10, 11=J, 12=Q, 13=K; 0=empty).
- SCORE_W, 4, width of a hand score (0..9).

Ports:
- slow_clock  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high
- pscore  in  SCORE_W  player hand score from datapath, mod 10
- dscore  in  SCORE_W  dealer hand score from datapath, mod 10
- pcard3  in  CARD_W  raw code held in the player third-card register
- load_pcard1/2/3  out  1 each  player card register load enables
- load_dcard1/2/3  out  1 each  dealer card register load enables
- player_win_light  out  1  player wins, or tie
- dealer_win_light  out  1  dealer wins, or tie

Behaviour:
- Clock and reset: one clock, slow_clock. reset is synchronous and active-high.
- Reset: state goes to S_P1; player_win_light and dealer_win_light go to 0; internal player_drew flag goes to 0. reset has priority over every transition, including mid-round and in S_DONE. The datapath card registers share this reset, so they read empty (0).
- Loads are Moore outputs. Exactly one load is high in its state, and the card is captured at the edge leaving that state. All loads are 0 in every other state.
- States and transitions:
  - S_P1 -> S_D1 -> S_P2 -> S_D2 -> S_EVAL1.
  - S_EVAL1: if pscore >= 8 or dscore >= 8 (natural), go to S_RESULT. Else if pscore <= 5, go to S_P3 and set player_drew. Else go to S_EVAL2 with player_drew = 0.
  - S_P3 -> S_EVAL2.
  - S_EVAL2: go to S_D3 if the banker draws, else S_RESULT.
  - S_D3 -> S_RESULT.
  - S_RESULT: register the lights and go to S_DONE.
  - S_DONE: hold until reset; loads are 0 and lights are held.
- Banker draw rule:
  - Third-card value v = 0 if pcard3 >= 10, else pcard3.
  - If player_drew = 0: draw iff dscore <= 5.
  - If player_drew = 1: draw iff any of the following:
    - dscore <= 2
    - dscore == 3 and v != 8
    - dscore == 4 and v in 2..7
    - dscore == 5 and v in 4..7
    - dscore == 6 and v in 6..7
  - Never draw on 7.
- Lights:
  - player_win_light = (pscore >= dscore).
  - dealer_win_light = (dscore >= pscore).
  - A tie lights both.
  - Compared in S_RESULT, so scores include every drawn card.
- Latency, counting the first cycle after reset release as cycle 0:
  - Natural: S_RESULT at cycle 5; lights valid from cycle 6.
  - Player stands, banker stands: lights at cycle 7.
  - Player stands, banker draws: lights at cycle 8.
  - Player draws, banker stands: lights at cycle 8.
  - Both draw: lights at cycle 9.
- Score inputs outside 0..9: the compare and rule logic use the raw values; no checking.

Optional Feature:
- Macro: BAC_ROUND_COUNT_EN.
- When defined:
  - Adds output round_count (4 bits).
  - Resets to 0 only when the synchronous input count_clr (1 bit, also added) is high.
  - Not cleared by reset, so rounds accumulate across resets.
  - Increments by 1 on the S_RESULT -> S_DONE edge and wraps from 15 to 0.
  - If count_clr and an increment coincide, clear wins.
- When undefined: neither port nor the counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package baccarat_pkg holds:
  - the state enum
  - constants NATURAL_MIN = 8, PLAYER_DRAW_MAX = 5, FACE_MIN = 10
  - function card_value(raw) giving the mod-10 card value
- One natural sub-module: banker_draw_rule, combinational.
  - Inputs: dscore, v, player_drew.
  - Output: draw.
  - Instantiated once and reusable by the verification model.

Test Plan:
- Natural: after P1..D2 load pscore=8, dscore=3 -> no load_pcard3 or load_dcard3; player_win_light=1 and dealer_win_light=0 at cycle 6.
- Both stand: pscore=6, dscore=7 -> cycle 5 in S_EVAL2, no third loads; dealer_win_light=1, player_win_light=0 at cycle 7.
- Player stands, banker draws: pscore=7, dscore=4 -> load_dcard3 at cycle 6; after the third card makes dscore=7, both lights are 1 (tie) at cycle 8.
- Player draws a face card: pscore=3, dscore=3, pcard3=12 (v=0) -> load_pcard3 at cycle 5 and load_dcard3 at cycle 7. Variant with pcard3=8 -> no load_dcard3; lights at cycle 8.
- Banker rule sweep: exhaustive dscore 0..7 x pcard3 0..13 x player_drew through banker_draw_rule against the table above.
- Reset mid-round: assert reset in S_P3 for one cycle -> next cycle state S_P1, lights 0, load_pcard1=1 again. With BAC_ROUND_COUNT_EN: round_count is unchanged by that reset and increments once per completed round.

Source files
------------

// File: rtl/baccarat_pkg.sv
// Shared types, rule thresholds and card helper for the baccarat round controller.
// Optional round counter is enabled with the BAC_ROUND_COUNT_EN macro (see top).
package baccarat_pkg;

    localparam int CARD_WIDTH  = 4;
    localparam int SCORE_WIDTH = 4;

    localparam int NATURAL_MIN     = 8;
    localparam int PLAYER_DRAW_MAX = 5;
    localparam int FACE_MIN        = 10;

    typedef enum logic [3:0] {
        S_P1     = 4'd0,
        S_D1     = 4'd1,
        S_P2     = 4'd2,
        S_D2     = 4'd3,
        S_EVAL1  = 4'd4,
        S_P3     = 4'd5,
        S_EVAL2  = 4'd6,
        S_D3     = 4'd7,
        S_RESULT = 4'd8,
        S_DONE   = 4'd9
    } state_e;

    // Tens and face cards (10, J, Q, K) all count as zero.
    function automatic logic [SCORE_WIDTH-1:0] card_value(input logic [CARD_WIDTH-1:0] raw);
        if (raw >= CARD_WIDTH'(FACE_MIN)) begin
            return '0;
        end
        return SCORE_WIDTH'(raw);
    endfunction

endpackage

// File: rtl/baccarat_deal_ctrl_if.sv
// Controller <-> datapath bundle: scores and third player card in, load enables and lights out.
// BAC_ROUND_COUNT_EN adds count_clr / round_count to the bundle.
interface baccarat_deal_ctrl_if #(
    parameter int CARD_W  = 4,
    parameter int SCORE_W = 4
);
    logic [SCORE_W-1:0] pscore;
    logic [SCORE_W-1:0] dscore;
    logic [CARD_W-1:0]  pcard3;
    logic               load_pcard1;
    logic               load_pcard2;
    logic               load_pcard3;
    logic               load_dcard1;
    logic               load_dcard2;
    logic               load_dcard3;
    logic               player_win_light;
    logic               dealer_win_light;
`ifdef BAC_ROUND_COUNT_EN
    logic               count_clr;
    logic [3:0]         round_count;

    modport master (
        output pscore, dscore, pcard3, count_clr,
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        input  player_win_light, dealer_win_light, round_count
    );

    modport slave (
        input  pscore, dscore, pcard3, count_clr,
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        output player_win_light, dealer_win_light, round_count
    );
`else
    modport master (
        output pscore, dscore, pcard3,
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        input  player_win_light, dealer_win_light
    );

    modport slave (
        input  pscore, dscore, pcard3,
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        output player_win_light, dealer_win_light
    );
`endif
endinterface

// File: rtl/banker_draw_rule.sv
// Combinational banker third-card decision from the banker score, the player's
// third-card value and whether the player drew at all.
module banker_draw_rule
    import baccarat_pkg::*;
#(
    parameter int SCORE_W = SCORE_WIDTH
) (
    input  logic [SCORE_W-1:0] dscore,
    input  logic [SCORE_W-1:0] v,
    input  logic               player_drew,
    output logic               draw
);

    logic v_2_7;
    logic v_4_7;
    logic v_6_7;

    assign v_2_7 = (v >= SCORE_W'(2)) && (v <= SCORE_W'(7));
    assign v_4_7 = (v >= SCORE_W'(4)) && (v <= SCORE_W'(7));
    assign v_6_7 = (v >= SCORE_W'(6)) && (v <= SCORE_W'(7));

    always_comb begin
        draw = 1'b0;
        if (!player_drew) begin
            draw = (dscore <= SCORE_W'(PLAYER_DRAW_MAX));
        end else if (dscore <= SCORE_W'(2)) begin
            draw = 1'b1;
        end else if (dscore == SCORE_W'(3)) begin
            draw = (v != SCORE_W'(8));
        end else if (dscore == SCORE_W'(4)) begin
            draw = v_2_7;
        end else if (dscore == SCORE_W'(5)) begin
            draw = v_4_7;
        end else if (dscore == SCORE_W'(6)) begin
            draw = v_6_7;
        end
    end

endmodule

// File: rtl/baccarat_deal_ctrl.sv
// Round sequencer: deals P1 D1 P2 D2, applies natural / third-card rules, latches win lights.
// Define BAC_ROUND_COUNT_EN to add a 4-bit completed-round counter with its own clear.
//
//   state    | meaning
//   S_P1     | load player card 1
//   S_D1     | load dealer card 1
//   S_P2     | load player card 2
//   S_D2     | load dealer card 2
//   S_EVAL1  | natural check, player draw decision
//   S_P3     | load player card 3
//   S_EVAL2  | banker draw decision
//   S_D3     | load dealer card 3
//   S_RESULT | compare final scores into lights
//   S_DONE   | idle with lights held until reset
module baccarat_deal_ctrl
    import baccarat_pkg::*;
#(
    parameter int CARD_W  = CARD_WIDTH,
    parameter int SCORE_W = SCORE_WIDTH
) (
    input  logic                 slow_clock,
    input  logic                 reset,
    baccarat_deal_ctrl_if.slave  bus
);

    state_e             state_q, state_d;
    logic               drew_q, drew_d;
    logic               pwin_q, pwin_d;
    logic               dwin_q, dwin_d;
    logic [5:0]         load;
    logic [CARD_W-1:0]  pcard3_raw;
    logic [SCORE_W-1:0] pcard3_v;
    logic               bank_draw;
    logic               natural;

    assign pcard3_raw = bus.pcard3;
    assign pcard3_v   = SCORE_W'(card_value(CARD_WIDTH'(pcard3_raw)));
    assign natural    = (bus.pscore >= SCORE_W'(NATURAL_MIN)) ||
                        (bus.dscore >= SCORE_W'(NATURAL_MIN));

    banker_draw_rule #(.SCORE_W(SCORE_W)) u_banker_rule (
        .dscore      (bus.dscore),
        .v           (pcard3_v),
        .player_drew (drew_q),
        .draw        (bank_draw)
    );

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state_q <= S_P1;
            drew_q  <= 1'b0;
            pwin_q  <= 1'b0;
            dwin_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drew_q  <= drew_d;
            pwin_q  <= pwin_d;
            dwin_q  <= dwin_d;
        end
    end

    // load = {pcard1, dcard1, pcard2, dcard2, pcard3, dcard3}
    always_comb begin
        state_d = state_q;
        drew_d  = drew_q;
        pwin_d  = pwin_q;
        dwin_d  = dwin_q;
        load    = 6'b000000;
        case (state_q)
            S_P1: begin
                load    = 6'b100000;
                state_d = S_D1;
            end
            S_D1: begin
                load    = 6'b010000;
                state_d = S_P2;
            end
            S_P2: begin
                load    = 6'b001000;
                state_d = S_D2;
            end
            S_D2: begin
                load    = 6'b000100;
                state_d = S_EVAL1;
            end
            S_EVAL1: begin
                if (natural) begin
                    drew_d  = 1'b0;
                    state_d = S_RESULT;
                end else if (bus.pscore <= SCORE_W'(PLAYER_DRAW_MAX)) begin
                    drew_d  = 1'b1;
                    state_d = S_P3;
                end else begin
                    drew_d  = 1'b0;
                    state_d = S_EVAL2;
                end
            end
            S_P3: begin
                load    = 6'b000010;
                state_d = S_EVAL2;
            end
            S_EVAL2: begin
                state_d = bank_draw ? S_D3 : S_RESULT;
            end
            S_D3: begin
                load    = 6'b000001;
                state_d = S_RESULT;
            end
            S_RESULT: begin
                pwin_d  = (bus.pscore >= bus.dscore);
                dwin_d  = (bus.dscore >= bus.pscore);
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_P1;
            end
        endcase
    end

    assign bus.load_pcard1      = load[5];
    assign bus.load_dcard1      = load[4];
    assign bus.load_pcard2      = load[3];
    assign bus.load_dcard2      = load[2];
    assign bus.load_pcard3      = load[1];
    assign bus.load_dcard3      = load[0];
    assign bus.player_win_light = pwin_q;
    assign bus.dealer_win_light = dwin_q;

`ifdef BAC_ROUND_COUNT_EN
    logic [3:0] count_q, count_d;

    // Deliberately outside reset so totals survive between rounds.
    always_comb begin
        count_d = count_q;
        if (bus.count_clr) begin
            count_d = 4'd0;
        end else if (!reset && state_q == S_RESULT) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge slow_clock) begin
        count_q <= count_d;
    end

    assign bus.round_count = count_q;
`endif

endmodule

// File: tb/tb_baccarat_deal_ctrl.sv
// Self-checking bench for baccarat_deal_ctrl: the bench plays the datapath and
// predicts each round from the game rules (directed + random rounds, rule sweep).
module tb_baccarat_deal_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    baccarat_deal_ctrl_if #(.CARD_W(4), .SCORE_W(4)) bus ();

    baccarat_deal_ctrl #(.CARD_W(4), .SCORE_W(4)) dut (
        .slow_clock (clk),
        .reset      (rst),
        .bus        (bus)
    );

    logic [3:0] r_d;
    logic [3:0] r_v;
    logic       r_drew;
    logic       r_draw;

    banker_draw_rule #(.SCORE_W(4)) u_rule (
        .dscore      (r_d),
        .v           (r_v),
        .player_drew (r_drew),
        .draw        (r_draw)
    );

    // bank_mask[d] bit v set <=> banker holding d draws after player's third card of value v
    logic [9:0] bank_mask [0:15];

    function automatic void build_masks();
        for (int d = 0; d < 16; d++) bank_mask[d] = 10'b0;
        bank_mask[0] = 10'b11_1111_1111;
        bank_mask[1] = 10'b11_1111_1111;
        bank_mask[2] = 10'b11_1111_1111;
        bank_mask[3] = 10'b10_1111_1111;
        bank_mask[4] = 10'b00_1111_1100;
        bank_mask[5] = 10'b00_1111_0000;
        bank_mask[6] = 10'b00_1100_0000;
    endfunction

    function automatic int face(input int raw);
        return (raw >= 10) ? 0 : raw;
    endfunction

    function automatic bit model_bank(input int d, input int v, input bit drew);
        if (!drew) return d <= 5;
        return bank_mask[d][v];
    endfunction

    function automatic logic [5:0] loads_now();
        return {bus.load_pcard1, bus.load_dcard1, bus.load_pcard2,
                bus.load_dcard2, bus.load_pcard3, bus.load_dcard3};
    endfunction

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_round(input string name, input int p0, input int d0,
                             input int pc, input int dc, input bit clr);
        logic [5:0] exp_ld [0:15];
        bit natural, pdraw, bdraw, got_p3, got_d3;
        int pf, df, lat;
        logic [5:0] ld;
        logic [1:0] lights, exp_lights;

        natural = (p0 >= 8) || (d0 >= 8);
        pdraw   = !natural && (p0 <= 5);
        bdraw   = !natural && model_bank(d0, pdraw ? face(pc) : 0, pdraw);
        pf      = pdraw ? (p0 + face(pc)) % 10 : p0;
        df      = bdraw ? (d0 + dc) % 10 : d0;
        lat     = natural ? 6 : 7 + int'(pdraw) + int'(bdraw);

        for (int i = 0; i < 16; i++) exp_ld[i] = 6'b0;
        exp_ld[0] = 6'b100000;
        exp_ld[1] = 6'b010000;
        exp_ld[2] = 6'b001000;
        exp_ld[3] = 6'b000100;
        if (pdraw) exp_ld[5] = 6'b000010;
        if (bdraw) exp_ld[pdraw ? 7 : 6] = 6'b000001;

        bus.pscore = 4'(p0);
        bus.dscore = 4'(d0);
        bus.pcard3 = 4'd0;
`ifdef BAC_ROUND_COUNT_EN
        bus.count_clr = clr;
`endif
        got_p3 = 1'b0;
        got_d3 = 1'b0;
        pulse_reset();

        for (int c = 0; c <= lat + 1; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
                if (got_p3) begin
                    bus.pcard3 = 4'(pc);
                    bus.pscore = 4'(pf);
                end
                if (got_d3) bus.dscore = 4'(df);
            end
            ld = loads_now();
            checks++;
            if (ld !== exp_ld[c]) begin
                errors++;
                $display("FAIL %s loads cycle %0d: got %b expected %b", name, c, ld, exp_ld[c]);
            end
            if (ld[1]) got_p3 = 1'b1;
            if (ld[0]) got_d3 = 1'b1;
            lights     = {bus.player_win_light, bus.dealer_win_light};
            exp_lights = (c >= lat) ? {pf >= df, df >= pf} : 2'b00;
            checks++;
            if (lights !== exp_lights) begin
                errors++;
                $display("FAIL %s lights cycle %0d: got %b expected %b", name, c, lights, exp_lights);
            end
        end

`ifdef BAC_ROUND_COUNT_EN
        exp_cnt = clr ? 0 : (exp_cnt + 1) % 16;
        bus.count_clr = 1'b0;
        checks++;
        if (bus.round_count !== 4'(exp_cnt)) begin
            errors++;
            $display("FAIL %s round_count: got %0d expected %0d", name, bus.round_count, exp_cnt);
        end
`else
        if (clr) exp_cnt = 0;
`endif
    endtask

    task automatic test_reset();
        bus.pscore = 4'd0;
        bus.dscore = 4'd0;
        bus.pcard3 = 4'd0;
`ifdef BAC_ROUND_COUNT_EN
        bus.count_clr = 1'b1;
`endif
        @(posedge clk);
        pulse_reset();
`ifdef BAC_ROUND_COUNT_EN
        bus.count_clr = 1'b0;
        exp_cnt = 0;
        checks++;
        if (bus.round_count !== 4'd0) begin
            errors++;
            $display("FAIL reset round_count: got %0d expected 0", bus.round_count);
        end
`endif
        checks++;
        if (loads_now() !== 6'b100000) begin
            errors++;
            $display("FAIL reset loads: got %b expected 100000", loads_now());
        end
        checks++;
        if ({bus.player_win_light, bus.dealer_win_light} !== 2'b00) begin
            errors++;
            $display("FAIL reset lights: got %b expected 00",
                     {bus.player_win_light, bus.dealer_win_light});
        end
    endtask

    task automatic test_directed();
        run_round("natural",        8, 3, 0,  0, 1'b0);
        run_round("both_stand",     6, 7, 0,  0, 1'b0);
        run_round("banker_draws",   7, 4, 0,  3, 1'b0);
        run_round("player_face",    3, 3, 12, 5, 1'b0);
        run_round("player_8_stand", 3, 3, 8,  0, 1'b0);
        run_round("dealer_natural", 2, 9, 0,  0, 1'b0);
    endtask

    task automatic test_rule_sweep();
        bit exp;
        for (int d = 0; d <= 7; d++) begin
            for (int pc = 0; pc <= 13; pc++) begin
                for (int dr = 0; dr <= 1; dr++) begin
                    r_d    = 4'(d);
                    r_v    = 4'(face(pc));
                    r_drew = dr[0];
                    #1;
                    exp = model_bank(d, face(pc), dr[0]);
                    checks++;
                    if (r_draw !== exp) begin
                        errors++;
                        $display("FAIL rule d=%0d pcard3=%0d drew=%0d: got %b expected %b",
                                 d, pc, dr, r_draw, exp);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_round();
        bus.pscore = 4'd3;
        bus.dscore = 4'd3;
        bus.pcard3 = 4'd0;
        pulse_reset();
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (loads_now() !== 6'b000010) begin
            errors++;
            $display("FAIL midreset reach_p3: got %b expected 000010", loads_now());
        end
        pulse_reset();
        checks++;
        if (loads_now() !== 6'b100000) begin
            errors++;
            $display("FAIL midreset loads: got %b expected 100000", loads_now());
        end
        checks++;
        if ({bus.player_win_light, bus.dealer_win_light} !== 2'b00) begin
            errors++;
            $display("FAIL midreset lights: got %b expected 00",
                     {bus.player_win_light, bus.dealer_win_light});
        end
`ifdef BAC_ROUND_COUNT_EN
        checks++;
        if (bus.round_count !== 4'(exp_cnt)) begin
            errors++;
            $display("FAIL midreset round_count: got %0d expected %0d", bus.round_count, exp_cnt);
        end
`endif
    endtask

    task automatic test_random_rounds();
        for (int n = 0; n < 40; n++) begin
            run_round("random", int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                      int'($urandom_range(0, 13)), int'($urandom_range(0, 9)), 1'b0);
        end
    endtask

    task automatic test_count_clear();
        run_round("clear_wins", 6, 6, 0, 0, 1'b1);
        run_round("after_clear", 9, 9, 0, 0, 1'b0);
    endtask

    initial begin
        build_masks();
        test_reset();
        test_directed();
        test_rule_sweep();
        test_reset_mid_round();
        test_random_rounds();
        test_count_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
